// File: rtl/reset_release_sequencer.sv
// Staged reset release: takes the synchronised system reset and releases
// NUM_STAGES downstream reset domains in ascending order, STAGE_DELAY cycles
// apart. A 4-phase software reset handshake re-asserts every stage, holds
// them low for SWRST_HOLD cycles and re-runs the sequence. scan_bypass lets
// every stage reset follow resetn directly.
module reset_release_sequencer #(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned STAGE_DELAY = 16,
  parameter int unsigned SWRST_HOLD  = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  scan_bypass,
  input  logic                  sw_rst_req,
  output logic                  sw_rst_ack,
  output logic [NUM_STAGES-1:0] stage_resetn,
  output logic                  all_released,
  output logic                  busy
);

  localparam int unsigned IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(SWRST_HOLD - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    ST_SEQ    = 2'd0,
    ST_DONE   = 2'd1,
    ST_SWHOLD = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NUM_STAGES-1:0]   stage_q, stage_d;
  logic                    all_rel_q, all_rel_d;
  logic                    busy_q, busy_d;
  logic                    ack_q, ack_d;
  logic                    pend_q, pend_d;
  logic [NUM_STAGES-1:0]   stage_bit;

  // One-hot select of the stage addressed by the release index
  always_comb begin
    for (int i = 0; i < NUM_STAGES; i++) begin
      stage_bit[i] = (idx_q == IDX_W'(i));
    end
  end

  // State register; synchronous reset overrides every state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_SEQ;
      cnt_q     <= '0;
      idx_q     <= '0;
      stage_q   <= '0;
      all_rel_q <= 1'b0;
      busy_q    <= 1'b1;
      ack_q     <= 1'b0;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      stage_q   <= stage_d;
      all_rel_q <= all_rel_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      pend_q    <= pend_d;
    end
  end

  // Next-state: release sequencing, software-reset hold and req/ack handshake
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    stage_d   = stage_q;
    all_rel_d = all_rel_q;
    busy_d    = busy_q;
    ack_d     = ack_q;
    pend_d    = pend_q;
    case (state_q)
      ST_SEQ: begin
        if (cnt_q == DELAY_LAST) begin
          cnt_d   = '0;
          idx_d   = idx_q + IDX_W'(1);
          stage_d = stage_q | stage_bit;
          if (idx_q == IDX_LAST) begin
            state_d   = ST_DONE;
            all_rel_d = 1'b1;
            busy_d    = 1'b0;
            // Acknowledge a software reset only once its re-sequence completes
            if (pend_q) begin
              ack_d  = 1'b1;
              pend_d = 1'b0;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SWHOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_SEQ;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (sw_rst_req && !ack_q) begin
          state_d   = ST_SWHOLD;
          stage_d   = '0;
          all_rel_d = 1'b0;
          busy_d    = 1'b1;
          pend_d    = 1'b1;
          cnt_d     = '0;
        end else if (!sw_rst_req) begin
          ack_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_SEQ;
      end
    endcase
  end

  // Scan mux is the only combinational path to the outputs
  assign stage_resetn = scan_bypass ? {NUM_STAGES{resetn}} : stage_q;
  assign all_released = scan_bypass ? resetn : all_rel_q;
  assign busy         = busy_q;
  assign sw_rst_ack   = ack_q;

endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed scenarios plus randomized
// resetn / scan_bypass / sw_rst_req traffic, compared every cycle against a
// count-based reference model for two parameterisations.
module tb_reset_release_sequencer;

  logic       clk;
  logic       resetn;
  logic       scan_bypass;
  logic       sw_rst_req;
  logic       ack0, ack1;
  logic [3:0] stage0;
  logic [0:0] stage1;
  logic       all0, all1;
  logic       busy0, busy1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  reset_release_sequencer #(
    .NUM_STAGES(4), .CNT_W(8), .STAGE_DELAY(16), .SWRST_HOLD(8)
  ) u_dut0 (
    .clk(clk), .resetn(resetn), .scan_bypass(scan_bypass),
    .sw_rst_req(sw_rst_req), .sw_rst_ack(ack0),
    .stage_resetn(stage0), .all_released(all0), .busy(busy0)
  );

  reset_release_sequencer #(
    .NUM_STAGES(1), .CNT_W(8), .STAGE_DELAY(1), .SWRST_HOLD(8)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .scan_bypass(scan_bypass),
    .sw_rst_req(sw_rst_req), .sw_rst_ack(ack1),
    .stage_resetn(stage1), .all_released(all1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per instance, released count = elapsed sequence edges / delay
  localparam int M_SEQ  = 0;
  localparam int M_DONE = 1;
  localparam int M_HOLD = 2;

  int unsigned p_n [2] = '{4, 1};
  int unsigned p_d [2] = '{16, 1};
  int unsigned p_h [2] = '{8, 8};

  int          m_mode [2];
  int unsigned m_t    [2];
  int unsigned m_h    [2];
  int unsigned m_rel  [2];
  logic        m_ack  [2];
  logic        m_pend [2];
  logic        m_busy [2];
  logic        m_all  [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_step(input int i);
    if (!resetn) begin
      m_mode[i] = M_SEQ; m_t[i] = 0; m_rel[i] = 0;
      m_ack[i] = 1'b0; m_pend[i] = 1'b0; m_busy[i] = 1'b1; m_all[i] = 1'b0;
    end else begin
      case (m_mode[i])
        M_SEQ: begin
          m_t[i]++;
          m_rel[i] = m_t[i] / p_d[i];
          if (m_rel[i] >= p_n[i]) begin
            m_rel[i] = p_n[i]; m_mode[i] = M_DONE;
            m_all[i] = 1'b1; m_busy[i] = 1'b0;
            if (m_pend[i]) begin m_ack[i] = 1'b1; m_pend[i] = 1'b0; end
          end
        end
        M_HOLD: begin
          m_h[i]++;
          if (m_h[i] == p_h[i]) begin m_mode[i] = M_SEQ; m_t[i] = 0; end
        end
        default: begin
          if (sw_rst_req && !m_ack[i]) begin
            m_mode[i] = M_HOLD; m_h[i] = 0; m_pend[i] = 1'b1;
            m_busy[i] = 1'b1; m_all[i] = 1'b0; m_rel[i] = 0;
          end else if (!sw_rst_req) begin
            m_ack[i] = 1'b0;
          end
        end
      endcase
    end
  endtask

  function automatic logic [31:0] exp_stage(input int i);
    if (scan_bypass) return resetn ? ((32'd1 << p_n[i]) - 32'd1) : 32'd0;
    return (32'd1 << m_rel[i]) - 32'd1;
  endfunction

  function automatic logic [31:0] exp_all(input int i);
    if (scan_bypass) return 32'(resetn);
    return 32'(m_all[i]);
  endfunction

  task automatic check_all();
    check("stage0", 32'(stage0), exp_stage(0));
    check("all0",   32'(all0),   exp_all(0));
    check("busy0",  32'(busy0),  32'(m_busy[0]));
    check("ack0",   32'(ack0),   32'(m_ack[0]));
    check("stage1", 32'(stage1), exp_stage(1));
    check("all1",   32'(all1),   exp_all(1));
    check("busy1",  32'(busy1),  32'(m_busy[1]));
    check("ack1",   32'(ack1),   32'(m_ack[1]));
  endtask

  // One clock: update the model on the active edge, return at the falling edge
  task automatic cycle();
    @(posedge clk);
    model_step(0);
    model_step(1);
    @(negedge clk);
  endtask

  initial begin
    int waited;
    resetn = 1'b0; scan_bypass = 1'b0; sw_rst_req = 1'b0;

    // Power-on reset then full release sequence
    for (int k = 0; k < 5; k++) begin
      cycle(); #1 check_all();
    end
    check("rst_stage0", 32'(stage0), 32'd0);
    check("rst_busy0",  32'(busy0),  32'd1);
    resetn = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      cycle(); #1 check_all();
      if (k == 1)  check("t6_stage1_e1",  32'(stage1), 32'd1);
      if (k == 1)  check("t6_all1_e1",    32'(all1),   32'd1);
      if (k == 15) check("t1_stage0_e15", 32'(stage0), 32'h0);
      if (k == 16) check("t1_stage0_e16", 32'(stage0), 32'h1);
      if (k == 32) check("t1_stage0_e32", 32'(stage0), 32'h3);
      if (k == 48) check("t1_stage0_e48", 32'(stage0), 32'h7);
      if (k == 63) check("t1_all0_e63",   32'(all0),   32'h0);
      if (k == 64) check("t1_stage0_e64", 32'(stage0), 32'hF);
      if (k == 64) check("t1_all0_e64",   32'(all0),   32'h1);
    end

    // Software reset handshake from DONE
    sw_rst_req = 1'b1;
    cycle(); #1 check_all();
    check("t2_stage0_low", 32'(stage0), 32'h0);
    waited = 0;
    while (!ack0 && waited < 300) begin
      cycle(); #1 check_all();
      waited++;
    end
    check("t2_ack_seen", 32'(ack0), 32'd1);
    check("t2_ack_latency", 32'(waited), 32'd72);
    sw_rst_req = 1'b0;
    cycle(); #1 check_all();
    check("t2_ack_drop", 32'(ack0), 32'd0);

    // One-cycle reset pulse mid-sequence
    resetn = 1'b0;
    cycle(); #1 check_all();
    resetn = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      cycle(); #1 check_all();
    end
    check("t3_stage0_e40", 32'(stage0), 32'h3);
    resetn = 1'b0;
    cycle(); #1 check_all();
    check("t3_stage0_rst", 32'(stage0), 32'h0);
    resetn = 1'b1;
    for (int k = 1; k <= 70; k++) begin
      cycle(); #1 check_all();
      if (k == 16) check("t3_stage0_e16", 32'(stage0), 32'h1);
    end

    // Request raised mid-sequence is served after DONE
    resetn = 1'b0;
    cycle(); #1 check_all();
    resetn = 1'b1;
    for (int k = 1; k <= 160; k++) begin
      if (k == 20) sw_rst_req = 1'b1;
      cycle(); #1 check_all();
      if (k == 64) check("t4_done_e64",  32'(all0),   32'h1);
      if (k == 65) check("t4_hold_e65",  32'(stage0), 32'h0);
      if (k == 65) check("t4_noack_e65", 32'(ack0),   32'h0);
    end
    sw_rst_req = 1'b0;
    cycle(); #1 check_all();

    // Scan bypass tracks resetn combinationally
    scan_bypass = 1'b1;
    #1 check_all();
    resetn = 1'b0;
    #1 check("t5_scan_low", 32'(stage0), 32'h0);
    resetn = 1'b1;
    #1 check("t5_scan_high", 32'(stage0), 32'hF);
    for (int k = 0; k < 20; k++) begin
      cycle(); resetn = (k % 5) != 0; #1 check_all();
    end
    resetn = 1'b1;
    cycle(); scan_bypass = 1'b0; #1 check_all();

    // Randomized traffic
    for (int k = 0; k < 4000; k++) begin
      cycle();
      resetn = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 39) == 0) scan_bypass = ~scan_bypass;
      if (!sw_rst_req && !m_ack[0] && $urandom_range(0, 59) == 0) sw_rst_req = 1'b1;
      else if (sw_rst_req && m_ack[0] && $urandom_range(0, 3) == 0) sw_rst_req = 1'b0;
      else if ($urandom_range(0, 499) == 0) sw_rst_req = ~sw_rst_req;
      #1 check_all();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
